// File: rtl/sdc_host_master.sv
// Client-side burst master for an SDRAM controller: command handshake, write buffer, read return.
// Optional watchdog enabled by defining SDC_HM_TIMEOUT_EN.
`ifndef U_ADDR_MSB
`define U_ADDR_MSB 25
`endif
`ifndef U_DATA_MSB
`define U_DATA_MSB 31
`endif

module sdc_host_master #(
    parameter int WBUF_DEPTH = 4,
    parameter int TMO_CYCLES = 255
) (
    input  logic                 mclk,
    input  logic                 s_reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [`U_ADDR_MSB:0] cmd_adr,
    input  logic [1:0]           cmd_len,
    input  logic                 cmd_wr_n,
    input  logic                 wbuf_push,
    input  logic [`U_DATA_MSB:0] wbuf_data,
    input  logic [3:0]           wbuf_be_n,
    output logic                 wbuf_full,
    output logic                 rsp_valid,
    output logic [`U_DATA_MSB:0] rsp_data,
    output logic                 done,
    output logic                 err,
    output logic                 sdr_req,
    output logic [`U_ADDR_MSB:0] sdr_req_adr,
    output logic [1:0]           sdr_req_len,
    output logic                 sdr_req_wr_n,
    output logic [`U_DATA_MSB:0] sdr_wr_data,
    output logic [3:0]           sdr_wr_en_n,
    input  logic                 sdr_req_ack,
    input  logic                 sdr_wr_next,
    input  logic                 sdr_rd_valid,
    input  logic [`U_DATA_MSB:0] sdr_rd_data,
    input  logic                 sdr_init_done
);
    localparam int AW = $clog2(WBUF_DEPTH);
    localparam int DW = `U_DATA_MSB + 1;

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;
    state_t state, state_nxt;

    logic [DW+3:0] mem [WBUF_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic [2:0]    beat;
    logic          push_ok, pop, beat_inc, last_beat, accept, tmo;

    assign wbuf_full = (occ == (AW+1)'(WBUF_DEPTH));
    assign push_ok   = wbuf_push && !wbuf_full;
    assign pop       = (state == WDATA) && sdr_wr_next && (occ != '0);
    assign beat_inc  = pop || ((state == RDATA) && sdr_rd_valid);
    assign last_beat = beat_inc && (beat == {1'b0, sdr_req_len});
    assign accept    = cmd_valid && cmd_ready;

    // Writes are only accepted once the whole burst is already buffered.
    assign cmd_ready = !s_reset && (state == IDLE) && sdr_init_done &&
                       (cmd_wr_n || (int'(occ) >= int'(cmd_len) + 1));

    assign {sdr_wr_en_n, sdr_wr_data} = mem[rd_ptr];

`ifdef SDC_HM_TIMEOUT_EN
    logic [7:0] wdog;
    logic       progress;
    assign progress = ((state == REQ) && sdr_req_ack) || beat_inc;
    assign tmo = (state != IDLE) && !progress && (wdog == 8'(TMO_CYCLES - 1));

    always_ff @(posedge mclk) begin
        if (s_reset || state == IDLE || progress) wdog <= '0;
        else                                      wdog <= wdog + 8'd1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (accept) state_nxt = REQ;
            REQ:          if (sdr_req_ack) state_nxt = sdr_req_wr_n ? RDATA : WDATA;
            WDATA, RDATA: if (last_beat) state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
        if (tmo) state_nxt = IDLE;
    end

    always_ff @(posedge mclk) begin
        if (s_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge mclk) begin
        if (push_ok) mem[wr_ptr] <= {wbuf_be_n, wbuf_data};
    end

    // Pointer width equals log2(depth), so increments wrap naturally.
    always_ff @(posedge mclk) begin
        if (s_reset || tmo) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (s_reset) begin
            sdr_req      <= 1'b0;
            sdr_req_adr  <= '0;
            sdr_req_len  <= '0;
            sdr_req_wr_n <= 1'b1;
            beat         <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (accept) begin
                sdr_req      <= 1'b1;
                sdr_req_adr  <= cmd_adr;
                sdr_req_len  <= cmd_len;
                sdr_req_wr_n <= cmd_wr_n;
            end else if ((state == REQ && sdr_req_ack) || tmo) begin
                sdr_req <= 1'b0;
            end

            if (state == REQ && sdr_req_ack) beat <= '0;
            else if (beat_inc)               beat <= beat + 3'd1;

            rsp_valid <= (state == RDATA) && sdr_rd_valid;
            if ((state == RDATA) && sdr_rd_valid) rsp_data <= sdr_rd_data;

            done <= last_beat && !tmo;
            // Error is sticky: overflow push, stray read data, or watchdog expiry.
            if ((wbuf_push && wbuf_full) || (sdr_rd_valid && state != RDATA) || tmo)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdc_host_master.sv
// Directed bench for sdc_host_master: write/read bursts, buffer gating, overflow, reset, watchdog.
`ifndef U_ADDR_MSB
`define U_ADDR_MSB 25
`endif
`ifndef U_DATA_MSB
`define U_DATA_MSB 31
`endif

module tb_sdc_host_master;
    logic                 mclk = 1'b0;
    logic                 s_reset;
    logic                 cmd_valid, cmd_ready, cmd_wr_n;
    logic [`U_ADDR_MSB:0] cmd_adr;
    logic [1:0]           cmd_len;
    logic                 wbuf_push, wbuf_full;
    logic [`U_DATA_MSB:0] wbuf_data;
    logic [3:0]           wbuf_be_n;
    logic                 rsp_valid, done, err;
    logic [`U_DATA_MSB:0] rsp_data;
    logic                 sdr_req, sdr_req_wr_n;
    logic [`U_ADDR_MSB:0] sdr_req_adr;
    logic [1:0]           sdr_req_len;
    logic [`U_DATA_MSB:0] sdr_wr_data, sdr_rd_data;
    logic [3:0]           sdr_wr_en_n;
    logic                 sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_init_done;

    int n_cmp = 0;
    int n_err = 0;

    sdc_host_master dut (
        .mclk(mclk), .s_reset(s_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
        .cmd_len(cmd_len), .cmd_wr_n(cmd_wr_n),
        .wbuf_push(wbuf_push), .wbuf_data(wbuf_data), .wbuf_be_n(wbuf_be_n),
        .wbuf_full(wbuf_full),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .err(err),
        .sdr_req(sdr_req), .sdr_req_adr(sdr_req_adr), .sdr_req_len(sdr_req_len),
        .sdr_req_wr_n(sdr_req_wr_n), .sdr_wr_data(sdr_wr_data), .sdr_wr_en_n(sdr_wr_en_n),
        .sdr_req_ack(sdr_req_ack), .sdr_wr_next(sdr_wr_next), .sdr_rd_valid(sdr_rd_valid),
        .sdr_rd_data(sdr_rd_data), .sdr_init_done(sdr_init_done)
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        wbuf_push = 1'b1;
        wbuf_data = d;
        tick();
        wbuf_push = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        s_reset = 1'b1; cmd_valid = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_wr_n = 1'b1;
        wbuf_push = 1'b0; wbuf_data = '0; wbuf_be_n = 4'h0;
        sdr_req_ack = 1'b0; sdr_wr_next = 1'b0; sdr_rd_valid = 1'b0; sdr_rd_data = '0;
        sdr_init_done = 1'b1;
        tick(); tick();
        chk("rst_sdr_req", sdr_req, 0);
        chk("rst_adr", sdr_req_adr, 0);
        chk("rst_len", sdr_req_len, 0);
        chk("rst_wr_n", sdr_req_wr_n, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wbuf_full", wbuf_full, 0);
        s_reset = 1'b0;
        tick();

        // Write burst of 4 beats
        for (int i = 1; i <= 4; i++) push(32'h11111111 * i);
        chk("wr_full_after4", wbuf_full, 1);
        cmd_valid = 1'b1; cmd_wr_n = 1'b0; cmd_len = 2'd3; cmd_adr = 'h100;
        #1 chk("wr_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("wr_sdr_req", sdr_req, 1);
        chk("wr_adr", sdr_req_adr, 'h100);
        chk("wr_len", sdr_req_len, 3);
        chk("wr_wr_n", sdr_req_wr_n, 0);
        tick();
        chk("wr_req_hold", sdr_req, 1);
        tick();
        sdr_req_ack = 1'b1;
        tick();
        sdr_req_ack = 1'b0;
        chk("wr_req_drop", sdr_req, 0);
        sdr_wr_next = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("wr_data%0d", i), sdr_wr_data, 32'h11111111 * i);
            chk($sformatf("wr_nodone%0d", i), done, 0);
            tick();
        end
        sdr_wr_next = 1'b0;
        chk("wr_done", done, 1);
        chk("wr_empty_full", wbuf_full, 0);
        tick();
        chk("wr_done_pulse", done, 0);
        cmd_len = 2'd0;
        #1 chk("wr_occ_zero", cmd_ready, 0);

        // Read burst of 2 beats
        cmd_valid = 1'b1; cmd_wr_n = 1'b1; cmd_len = 2'd1; cmd_adr = 'h200;
        #1 chk("rd_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("rd_sdr_req", sdr_req, 1);
        chk("rd_adr", sdr_req_adr, 'h200);
        chk("rd_wr_n", sdr_req_wr_n, 1);
        sdr_req_ack = 1'b1;
        tick();
        sdr_req_ack = 1'b0;
        sdr_rd_valid = 1'b1; sdr_rd_data = 32'hDEADBEEF;
        #1 chk("rd_no_early_rsp", rsp_valid, 0);
        tick();
        chk("rd_rsp1_valid", rsp_valid, 1);
        chk("rd_rsp1_data", rsp_data, 32'hDEADBEEF);
        chk("rd_rsp1_nodone", done, 0);
        sdr_rd_data = 32'hCAFEF00D;
        tick();
        sdr_rd_valid = 1'b0;
        chk("rd_rsp2_valid", rsp_valid, 1);
        chk("rd_rsp2_data", rsp_data, 32'hCAFEF00D);
        chk("rd_done", done, 1);
        tick();
        chk("rd_rsp_end", rsp_valid, 0);
        chk("rd_done_pulse", done, 0);
        chk("rd_no_err", err, 0);

        // init_done gates accepts only
        sdr_init_done = 1'b0;
        #1 chk("init_gate", cmd_ready, 0);
        sdr_init_done = 1'b1; cmd_valid = 1'b1; cmd_len = 2'd0;
        tick();
        cmd_valid = 1'b0; sdr_init_done = 1'b0;
        sdr_req_ack = 1'b1;
        tick();
        sdr_req_ack = 1'b0; sdr_rd_valid = 1'b1; sdr_rd_data = 32'h55;
        tick();
        sdr_rd_valid = 1'b0;
        chk("init_drop_rsp", rsp_data, 32'h55);
        chk("init_drop_done", done, 1);
        sdr_init_done = 1'b1;

        // Write gating on occupancy, then overflow
        push(32'hA0); push(32'hA1);
        cmd_wr_n = 1'b0; cmd_len = 2'd3;
        #1 chk("gate_2words", cmd_ready, 0);
        push(32'hA2); push(32'hA3);
        chk("gate_4words", cmd_ready, 1);
        chk("ovf_full", wbuf_full, 1);
        chk("ovf_err_before", err, 0);
        push(32'hA4);
        chk("ovf_err", err, 1);
        chk("ovf_still_full", wbuf_full, 1);

        // Reset during WDATA after 2 beats
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; sdr_req_ack = 1'b1;
        tick();
        sdr_req_ack = 1'b0; sdr_wr_next = 1'b1;
        chk("rst_mid_data0", sdr_wr_data, 32'hA0);
        tick();
        chk("rst_mid_data1", sdr_wr_data, 32'hA1);
        tick();
        s_reset = 1'b1; sdr_req_ack = 1'b1;
        tick();
        s_reset = 1'b0; sdr_req_ack = 1'b0; sdr_wr_next = 1'b0;
        chk("rst_mid_req", sdr_req, 0);
        chk("rst_mid_err", err, 0);
        chk("rst_mid_full", wbuf_full, 0);
        chk("rst_mid_done", done, 0);
        cmd_wr_n = 1'b1;
        #1 chk("rst_mid_idle", cmd_ready, 1);
        cmd_wr_n = 1'b0; cmd_len = 2'd0;
        #1 chk("rst_mid_flush", cmd_ready, 0);

        // Stray controller strobes in IDLE
        push(32'hB0);
        sdr_wr_next = 1'b1;
        tick();
        sdr_wr_next = 1'b0;
        chk("stray_next_nopop", cmd_ready, 1);
        cmd_len = 2'd1;
        #1 chk("stray_next_occ1", cmd_ready, 0);
        chk("stray_next_noerr", err, 0);
        sdr_rd_valid = 1'b1;
        tick();
        sdr_rd_valid = 1'b0;
        chk("stray_rd_err", err, 1);
        chk("stray_rd_norsp", rsp_valid, 0);
        s_reset = 1'b1;
        tick();
        s_reset = 1'b0;
        chk("rst2_err", err, 0);

        // Unacked request
        cmd_valid = 1'b1; cmd_wr_n = 1'b1; cmd_len = 2'd0;
        tick();
        cmd_valid = 1'b0;
        chk("wd_req_rise", sdr_req, 1);
`ifdef SDC_HM_TIMEOUT_EN
        begin
            logic seen_done = 1'b0;
            for (int i = 0; i < 254; i++) begin
                tick();
                seen_done |= done;
            end
            chk("wd_err_254", err, 0);
            chk("wd_req_254", sdr_req, 1);
            tick();
            seen_done |= done;
            chk("wd_err_255", err, 1);
            chk("wd_req_255", sdr_req, 0);
            chk("wd_no_done", seen_done, 0);
            #1 chk("wd_idle", cmd_ready, 1);
        end
`else
        for (int i = 0; i < 300; i++) tick();
        chk("nowd_req_held", sdr_req, 1);
        chk("nowd_no_err", err, 0);
        sdr_req_ack = 1'b1;
        tick();
        sdr_req_ack = 1'b0; sdr_rd_valid = 1'b1; sdr_rd_data = 32'h77;
        tick();
        sdr_rd_valid = 1'b0;
        chk("nowd_done", done, 1);
        chk("nowd_rsp", rsp_data, 32'h77);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sdc_host_master.md
SDC_HOST_MASTER -- requirements
Module: sdc_host_master

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 4, write-buffer depth in words (power of 2, >=4).
REQ-002 SHALL have parameter TMO_CYCLES, default 255, watchdog limit in mclk cycles (8-bit max).
REQ-003 SHALL have port mclk, in, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port s_reset, in, 1, synchronous active-high reset.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_adr in `U_ADDR_MSB+1, cmd_len in 2 (beats = len+1), cmd_wr_n in 1 (0 = write): client command handshake.
REQ-006 SHALL have ports wbuf_push in 1, wbuf_data in `U_DATA_MSB+1, wbuf_be_n in 4, wbuf_full out 1: client write-data push.
REQ-007 SHALL have ports rsp_valid out 1, rsp_data out `U_DATA_MSB+1, done out 1, err out 1: read data, completion pulse, sticky error.
REQ-008 SHALL have controller-side outputs sdr_req 1, sdr_req_adr `U_ADDR_MSB+1, sdr_req_len 2, sdr_req_wr_n 1, sdr_wr_data `U_DATA_MSB+1, sdr_wr_en_n 4.
REQ-009 SHALL have controller-side inputs sdr_req_ack 1, sdr_wr_next 1, sdr_rd_valid 1, sdr_rd_data `U_DATA_MSB+1, sdr_init_done 1.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WDATA, RDATA.
REQ-011 cmd_ready SHALL be 1 only in IDLE with sdr_init_done=1 and, for writes, wbuf occupancy >= cmd_len+1.
REQ-012 On cmd_valid&cmd_ready, SHALL register adr/len/wr_n onto sdr_req_* and assert sdr_req next cycle; IDLE->REQ.
REQ-013 In REQ, sdr_req and sdr_req_* SHALL stay stable until sdr_req_ack sampled 1; sdr_req deasserts the following cycle.
REQ-014 On ack: REQ->WDATA if write, REQ->RDATA if read; beat counter cleared.
REQ-015 sdr_wr_data/sdr_wr_en_n SHALL combinationally present the wbuf head word; each cycle sdr_wr_next=1 in WDATA pops one word and increments the beat counter.
REQ-016 When beat counter reaches len+1 in WDATA or RDATA: return to IDLE, pulse done for 1 cycle.
REQ-017 In RDATA, each sdr_rd_valid=1 cycle SHALL register sdr_rd_data to rsp_data with rsp_valid=1 one cycle later (latency 1, no backpressure).
REQ-018 sdr_wr_next outside WDATA SHALL be ignored (no pop); sdr_rd_valid outside RDATA SHALL set err, data dropped.
REQ-019 wbuf_push when full SHALL be dropped and set err; push and pop in same cycle SHALL keep occupancy constant.
REQ-020 wbuf_full SHALL equal (occupancy == WBUF_DEPTH); pointers wrap modulo WBUF_DEPTH.
REQ-021 sdr_init_done falling mid-transaction SHALL NOT abort it; it gates only new accepts.
REQ-022 err SHALL stay set until s_reset.

Reset
REQ-023 s_reset SHALL force IDLE, flush wbuf (occupancy 0), clear beat and watchdog counters.
REQ-024 Reset values: sdr_req=0, sdr_req_adr=0, sdr_req_len=0, sdr_req_wr_n=1, rsp_valid=0, rsp_data=0, done=0, err=0, cmd_ready=0, wbuf_full=0.
REQ-025 Reset asserted mid-burst SHALL take effect the next edge regardless of controller handshakes.

Configuration
REQ-026 Macro SDC_HM_TIMEOUT_EN defined: 8-bit watchdog counts cycles in REQ/WDATA/RDATA without ack or beat; at TMO_CYCLES sets err, returns IDLE, flushes wbuf, no done pulse.
REQ-027 Macro SDC_HM_TIMEOUT_EN undefined: no watchdog logic; FSM waits indefinitely.

Verification
REQ-028 Push 4 words 0x11111111..0x44444444, write cmd len=3 adr=0x100; ack after 2 cycles, wr_next 4 cycles -> sdr_wr_data sequence matches, done once, occupancy 0.
REQ-029 Read cmd len=1 adr=0x200; ack, rd_valid with 0xDEADBEEF, 0xCAFEF00D -> rsp_valid twice, 1 cycle later each, done after second.
REQ-030 Write cmd len=3 with 2 words buffered -> cmd_ready=0; after 2 more pushes -> cmd_ready=1.
REQ-031 Push 5 words with WBUF_DEPTH=4 -> wbuf_full=1 after 4th, err=1 after 5th; sdr_rd_valid pulse in IDLE -> err=1.
REQ-032 s_reset during WDATA after 2 beats -> next cycle sdr_req=0, state IDLE, wbuf_full=0, err=0.
REQ-033 With SDC_HM_TIMEOUT_EN, never ack -> err=1 exactly TMO_CYCLES=255 cycles after sdr_req rises, sdr_req=0, no done.
